// File: rtl/dcache_control.sv
`default_nettype none
// ============================================================================
// Module   : dcache_control
// Brief    : Control FSM for a two-way, write-back, write-allocate data cache.
//            Optional macro DCACHE_PERF_CNT_EN adds saturating hit, miss and
//            writeback counters.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_control #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 5,
    parameter int S_MASK   = 2**S_OFFSET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [S_MASK-1:0] mem_byte_enable256,
    output logic              mem_resp,
    input  logic              pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic              mem_read_delayed,
    output logic              mem_write_delayed,
    input  logic [1:0]        hit_datapath,
    input  logic              lru_output,
    input  logic [1:0]        valid_out,
    input  logic [1:0]        dirty_out,
    output logic              mem_enable_sel,
    output logic [S_MASK-1:0] write_enable_0,
    output logic [S_MASK-1:0] write_enable_1,
    output logic [1:0]        wren,
    output logic [1:0]        load_tag,
    output logic [1:0]        load_valid,
    output logic [1:0]        set_valid,
    output logic [1:0]        load_dirty,
    output logic [1:0]        set_dirty,
    output logic              load_lru,
    output logic              set_lru
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       writeback_count
`endif
);

    localparam logic [2:0] C_ST_IDLE      = 3'd0;
    localparam logic [2:0] C_ST_LOOKUP    = 3'd1;
    localparam logic [2:0] C_ST_WRITEBACK = 3'd2;
    localparam logic [2:0] C_ST_FILL      = 3'd3;
    localparam logic [2:0] C_ST_SETTLE    = 3'd4;

    if (S_OFFSET < 1 || S_INDEX < 1 || S_MASK != 2**S_OFFSET) begin : g_param_check
        $error("dcache_control: inconsistent geometry parameters");
    end

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              r_is_write;
    logic [S_MASK-1:0] r_ben;
    logic              r_victim;
    logic              r_read_delayed;
    logic              r_write_delayed;
    logic              w_hit;
    logic              w_hit_way;
    logic              w_victim_dirty;
    logic              w_accept;

    // Way 0 takes priority when both ways report a hit.
    assign w_hit          = |hit_datapath;
    assign w_hit_way      = ~hit_datapath[0];
    assign w_victim_dirty = valid_out[lru_output] & dirty_out[lru_output];
    assign w_accept       = (r_state == C_ST_IDLE) && (mem_read || mem_write);

    assign mem_read_delayed  = r_read_delayed;
    assign mem_write_delayed = r_write_delayed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= C_ST_IDLE;
            r_is_write      <= 1'b0;
            r_ben           <= '0;
            r_victim        <= 1'b0;
            r_read_delayed  <= 1'b0;
            r_write_delayed <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_is_write      <= mem_write;
                r_ben           <= mem_byte_enable256;
                r_read_delayed  <= mem_read & ~mem_write;
                r_write_delayed <= mem_write;
            end
            if (mem_resp) begin
                r_read_delayed  <= 1'b0;
                r_write_delayed <= 1'b0;
            end
            if (r_state == C_ST_LOOKUP && !w_hit) begin
                r_victim <= lru_output;
            end
        end
    end

    always_comb begin
        w_next_state   = r_state;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        mem_enable_sel = 1'b0;
        write_enable_0 = '0;
        write_enable_1 = '0;
        wren           = 2'b00;
        load_tag       = 2'b00;
        load_valid     = 2'b00;
        set_valid      = 2'b00;
        load_dirty     = 2'b00;
        set_dirty      = 2'b00;
        load_lru       = 1'b0;
        set_lru        = 1'b0;

        case (r_state)
            C_ST_IDLE: begin
                if (mem_read || mem_write) begin
                    w_next_state = C_ST_LOOKUP;
                end
            end
            C_ST_LOOKUP: begin
                if (w_hit) begin
                    mem_resp     = 1'b1;
                    load_lru     = 1'b1;
                    set_lru      = ~w_hit_way;
                    w_next_state = C_ST_IDLE;
                    if (r_is_write) begin
                        wren[w_hit_way]       = 1'b1;
                        load_dirty[w_hit_way] = 1'b1;
                        set_dirty[w_hit_way]  = 1'b1;
                        if (w_hit_way) begin
                            write_enable_1 = r_ben;
                        end else begin
                            write_enable_0 = r_ben;
                        end
                    end
                end else begin
                    w_next_state = w_victim_dirty ? C_ST_WRITEBACK : C_ST_FILL;
                end
            end
            C_ST_WRITEBACK: begin
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    load_dirty[r_victim] = 1'b1;
                    w_next_state         = C_ST_FILL;
                end
            end
            C_ST_FILL: begin
                pmem_read      = 1'b1;
                mem_enable_sel = 1'b1;
                if (pmem_resp) begin
                    wren[r_victim]       = 1'b1;
                    load_tag[r_victim]   = 1'b1;
                    load_valid[r_victim] = 1'b1;
                    set_valid[r_victim]  = 1'b1;
                    load_dirty[r_victim] = 1'b1;
                    if (r_victim) begin
                        write_enable_1 = '1;
                    end else begin
                        write_enable_0 = '1;
                    end
                    w_next_state = C_ST_SETTLE;
                end
            end
            C_ST_SETTLE: begin
                w_next_state = C_ST_LOOKUP;
            end
            default: begin
                w_next_state = C_ST_IDLE;
            end
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic        r_after_settle;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic [31:0] r_writeback_count;

    assign hit_count       = r_hit_count;
    assign miss_count      = r_miss_count;
    assign writeback_count = r_writeback_count;

    // The post-fill lookup is the tail of a miss, not a fresh hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_after_settle    <= 1'b0;
            r_hit_count       <= '0;
            r_miss_count      <= '0;
            r_writeback_count <= '0;
        end else begin
            r_after_settle <= (r_state == C_ST_SETTLE);
            if (r_state == C_ST_LOOKUP && w_hit && !r_after_settle && r_hit_count != '1) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (r_state == C_ST_LOOKUP && !w_hit && r_miss_count != '1) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
            if (r_state == C_ST_WRITEBACK && pmem_resp && r_writeback_count != '1) begin
                r_writeback_count <= r_writeback_count + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_control
// Brief    : Randomised self-checking bench for dcache_control against a
//            transaction-level two-way cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_byte_enable256;
    logic        mem_resp;
    logic        pmem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic        mem_read_delayed;
    logic        mem_write_delayed;
    logic [1:0]  hit_datapath;
    logic        lru_output;
    logic [1:0]  valid_out;
    logic [1:0]  dirty_out;
    logic        mem_enable_sel;
    logic [31:0] write_enable_0;
    logic [31:0] write_enable_1;
    logic [1:0]  wren;
    logic [1:0]  load_tag;
    logic [1:0]  load_valid;
    logic [1:0]  set_valid;
    logic [1:0]  load_dirty;
    logic [1:0]  set_dirty;
    logic        load_lru;
    logic        set_lru;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] writeback_count;
`endif

    dcache_control u_dut (
        .clk                (clk),
        .rst                (rst),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_byte_enable256 (mem_byte_enable256),
        .mem_resp           (mem_resp),
        .pmem_resp          (pmem_resp),
        .pmem_read          (pmem_read),
        .pmem_write         (pmem_write),
        .mem_read_delayed   (mem_read_delayed),
        .mem_write_delayed  (mem_write_delayed),
        .hit_datapath       (hit_datapath),
        .lru_output         (lru_output),
        .valid_out          (valid_out),
        .dirty_out          (dirty_out),
        .mem_enable_sel     (mem_enable_sel),
        .write_enable_0     (write_enable_0),
        .write_enable_1     (write_enable_1),
        .wren               (wren),
        .load_tag           (load_tag),
        .load_valid         (load_valid),
        .set_valid          (set_valid),
        .load_dirty         (load_dirty),
        .set_dirty          (set_dirty),
        .load_lru           (load_lru),
        .set_lru            (set_lru)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count),
        .writeback_count    (writeback_count)
`endif
    );

    always #5 clk = ~clk;

    // Emulated datapath arrays, updated only from the DUT strobes.
    bit   [1:0] env_valid [32];
    bit   [1:0] env_dirty [32];
    logic [7:0] env_tag   [32][2];
    bit         env_lru   [32];
    logic [4:0] cur_set;
    logic [7:0] cur_tag;

    // Reference cache state, updated per transaction.
    bit   [1:0] ref_valid [32];
    bit   [1:0] ref_dirty [32];
    logic [7:0] ref_tag   [32][2];
    bit         ref_lru   [32];
    int         ref_hits, ref_misses, ref_wbs;

    int n_cmp = 0;
    int n_bad = 0;
    int n_overlap = 0;

    assign hit_datapath[0] = env_valid[cur_set][0] && (env_tag[cur_set][0] == cur_tag);
    assign hit_datapath[1] = env_valid[cur_set][1] && (env_tag[cur_set][1] == cur_tag);
    assign valid_out       = env_valid[cur_set];
    assign dirty_out       = env_dirty[cur_set];
    assign lru_output      = env_lru[cur_set];

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] all_outputs();
        return {mem_resp, pmem_read, pmem_write, mem_read_delayed, mem_write_delayed,
                mem_enable_sel, wren, load_tag, load_valid, set_valid, load_dirty,
                set_dirty, load_lru, set_lru, |write_enable_0, |write_enable_1};
    endfunction

    function automatic logic [20:0] env_set(input int s);
        return {env_valid[s], env_dirty[s], env_tag[s][0], env_tag[s][1], env_lru[s]};
    endfunction

    function automatic logic [20:0] ref_set(input int s);
        return {ref_valid[s], ref_dirty[s], ref_tag[s][0], ref_tag[s][1], ref_lru[s]};
    endfunction

    task automatic run_txn(input int s, input logic [7:0] t, input bit rd, input bit wr,
                           input logic [31:0] ben, input int wbw, input int flw);
        bit          exp_hit, exp_wb, done;
        int          hw, v, exp_lat, cyc, lat, wb_cnt, fl_cnt;
        logic [1:0]  exp_cpu_wren, exp_fill_wren, obs_cpu_wren, obs_fill_wren, obs_delayed;
        logic [31:0] obs_cpu_we, obs_fill_we;
        logic [1:0]  s_lt, s_lv, s_sv, s_ld, s_sd;
        logic        s_ll, s_sl;

        exp_hit = 1'b0;
        exp_wb  = 1'b0;
        hw      = 0;
        if (ref_valid[s][0] && ref_tag[s][0] == t) begin
            exp_hit = 1'b1;
            hw      = 0;
        end else if (ref_valid[s][1] && ref_tag[s][1] == t) begin
            exp_hit = 1'b1;
            hw      = 1;
        end
        if (exp_hit) begin
            exp_lat       = 1;
            exp_fill_wren = 2'b00;
            ref_hits++;
        end else begin
            v                = int'(ref_lru[s]);
            exp_wb           = ref_valid[s][v] && ref_dirty[s][v];
            ref_valid[s][v]  = 1'b1;
            ref_tag[s][v]    = t;
            ref_dirty[s][v]  = 1'b0;
            hw               = v;
            exp_lat          = 3 + (exp_wb ? wbw : 0) + flw;
            exp_fill_wren    = 2'b01 << v;
            ref_misses++;
            if (exp_wb) ref_wbs++;
        end
        ref_lru[s] = (hw == 0);
        if (wr) ref_dirty[s][hw] = 1'b1;
        exp_cpu_wren = wr ? (2'b01 << hw) : 2'b00;

        @(negedge clk);
        cur_set            = 5'(s);
        cur_tag            = t;
        mem_read           = rd;
        mem_write          = wr;
        mem_byte_enable256 = ben;
        done = 1'b0; cyc = 0; lat = -1; wb_cnt = 0; fl_cnt = 0;
        obs_cpu_wren = 2'b00; obs_fill_wren = 2'b00; obs_cpu_we = '0; obs_fill_we = '0;
        obs_delayed = 2'b00;
        while (!done && cyc < 64) begin
            #1;
            pmem_resp = (pmem_write && wb_cnt + 1 == wbw) || (pmem_read && fl_cnt + 1 == flw);
            #1;
            if (pmem_write) wb_cnt++;
            if (pmem_read) fl_cnt++;
            if (pmem_read && pmem_write) n_overlap++;
            if (|wren) begin
                if (mem_enable_sel) begin
                    obs_fill_wren |= wren;
                    obs_fill_we    = wren[1] ? write_enable_1 : write_enable_0;
                end else begin
                    obs_cpu_wren |= wren;
                    obs_cpu_we    = wren[1] ? write_enable_1 : write_enable_0;
                end
            end
            if (mem_resp) begin
                done        = 1'b1;
                lat         = cyc;
                obs_delayed = {mem_write_delayed, mem_read_delayed};
            end
            s_lt = load_tag; s_lv = load_valid; s_sv = set_valid;
            s_ld = load_dirty; s_sd = set_dirty; s_ll = load_lru; s_sl = set_lru;
            @(posedge clk);
            #1;
            for (int w = 0; w < 2; w++) begin
                if (s_lt[w]) env_tag[s][w]   = t;
                if (s_lv[w]) env_valid[s][w] = s_sv[w];
                if (s_ld[w]) env_dirty[s][w] = s_sd[w];
            end
            if (s_ll) env_lru[s] = s_sl;
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) check_value("mem_resp_timeout", 64'd0, 64'd1);

        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pmem_resp = 1'b0;
        #1;
        check_value("latency", 64'(lat), 64'(exp_lat));
        check_value("wb_cycles", 64'(wb_cnt), 64'(exp_wb ? wbw : 0));
        check_value("fill_cycles", 64'(fl_cnt), 64'(exp_hit ? 0 : flw));
        check_value("cpu_wren", 64'(obs_cpu_wren), 64'(exp_cpu_wren));
        check_value("cpu_byte_en", 64'(obs_cpu_we), 64'(wr ? ben : 32'd0));
        check_value("fill_wren", 64'(obs_fill_wren), 64'(exp_fill_wren));
        check_value("fill_byte_en", 64'(obs_fill_we), exp_hit ? 64'd0 : 64'hFFFF_FFFF);
        check_value("delayed_flags", 64'(obs_delayed), 64'({wr, rd & ~wr}));
        check_value("set_state", 64'(env_set(s)), 64'(ref_set(s)));
        check_value("idle_after", 64'({mem_resp, mem_read_delayed, mem_write_delayed, pmem_read, pmem_write}), 64'd0);
    endtask

    initial begin
        int op;
        bit reached;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable256 = '0;
        pmem_resp = 1'b0; cur_set = '0; cur_tag = '0;
        ref_hits = 0; ref_misses = 0; ref_wbs = 0;
        for (int i = 0; i < 32; i++) begin
            env_valid[i] = '0; env_dirty[i] = '0; env_lru[i] = 1'b0;
            ref_valid[i] = '0; ref_dirty[i] = '0; ref_lru[i] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                env_tag[i][w] = '0;
                ref_tag[i][w] = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_outputs", 64'(all_outputs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset during a fill abandons the request with no response.
        @(negedge clk);
        cur_set = 5'd9; cur_tag = 8'd5; mem_read = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            @(negedge clk);
            #1;
            if (pmem_read) reached = 1'b1;
        end
        check_value("fill_reached", 64'(reached), 64'd1);
        @(negedge clk);
        check_value("fill_pending", 64'({pmem_read, mem_enable_sel, mem_resp}), 64'b110);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_value("abort_outputs", 64'(all_outputs()), 64'd0);
        rst = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        check_value("abort_quiet", 64'(all_outputs()), 64'd0);

        run_txn(9, 8'd5, 1'b1, 1'b0, 32'h0, 1, 4);
        run_txn(9, 8'd5, 1'b0, 1'b1, 32'h0000_000F, 1, 1);
        run_txn(9, 8'd6, 1'b1, 1'b0, 32'h0, 1, 2);
        run_txn(9, 8'd6, 1'b1, 1'b0, 32'h0, 1, 1);
        run_txn(9, 8'd6, 1'b0, 1'b1, 32'hF0F0_0001, 1, 1);
        run_txn(9, 8'd5, 1'b1, 1'b0, 32'h0, 1, 1);
        run_txn(9, 8'd7, 1'b1, 1'b0, 32'h0, 3, 2);
        run_txn(9, 8'd7, 1'b1, 1'b1, 32'h8000_0000, 1, 1);

        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 3));
            run_txn(int'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                    op != 2, op >= 2, $urandom,
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end

        check_value("pmem_overlap", 64'(n_overlap), 64'd0);
`ifdef DCACHE_PERF_CNT_EN
        check_value("hit_count", 64'(hit_count), 64'(ref_hits));
        check_value("miss_count", 64'(miss_count), 64'(ref_misses));
        check_value("writeback_count", 64'(writeback_count), 64'(ref_wbs));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_control.md
Name: dcache_control

Overview:
- Control FSM that sequences the two-way, write-back, write-allocate data cache datapath.
- Accepts CPU read and write requests and resolves hit or miss using the datapath's hit/valid/dirty/LRU outputs.
- Drives writeback and line fill to physical memory.
- Generates every load/write-enable strobe the datapath consumes; has no data-path logic of its own.

Parameters:
s_offset, 5, byte-offset bits per 256-bit line
s_index, 5, index bits (32 sets)
s_mask, 2**s_offset, byte-enable width per line (32)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_byte_enable256  in  s_mask  CPU byte enables, line-aligned
mem_resp  out  1  one-cycle CPU completion pulse
pmem_resp  in  1  physical memory completion pulse
pmem_read  out  1  line fill request to memory
pmem_write  out  1  writeback request to memory
mem_read_delayed  out  1  registered read-in-progress flag to datapath
mem_write_delayed  out  1  registered write-in-progress flag to datapath
hit_datapath  in  2  per-way hit {hit_1,hit_0}
lru_output  in  1  LRU way of current set (victim)
valid_out  in  2  per-way valid
dirty_out  in  2  per-way dirty
mem_enable_sel  out  1  1 = array data from pmem_rdata
write_enable_0  out  s_mask  way 0 byte enables
write_enable_1  out  s_mask  way 1 byte enables
wren  out  2  per-way data array write
load_tag  out  2  per-way tag write
load_valid  out  2  per-way valid write
set_valid  out  2  valid write value
load_dirty  out  2  per-way dirty write
set_dirty  out  2  dirty write value
load_lru  out  1  LRU write
set_lru  out  1  LRU write value

Behaviour:
- Reset: state IDLE; all outputs 0, including the delayed flags, the victim register and the counters.
- Reset asserted mid-operation aborts it: pmem_read/pmem_write drop in the next cycle and no CPU response is issued.
- Every strobe not listed for a state is 0.
- States: IDLE, LOOKUP, WRITEBACK, FILL, SETTLE.
- IDLE:
  - On mem_read|mem_write: register the operation (write wins if both are asserted) and mem_byte_enable256, then go to LOOKUP.
  - The delayed flags go high with the transition and stay high until mem_resp.
- LOOKUP, hit (hit_datapath != 0; 2'b11 resolves to way 0):
  - mem_resp=1 for one cycle; load_lru=1; set_lru = ~hit_way.
  - Write hit additionally asserts: wren[w]=1; write_enable_w = registered byte enables; load_dirty[w]=1; set_dirty[w]=1; mem_enable_sel=0.
  - Next state IDLE.
- LOOKUP, miss:
  - Latch victim v = lru_output.
  - If valid_out[v] & dirty_out[v], go to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - pmem_write=1 until pmem_resp.
  - In the pmem_resp cycle: load_dirty[v]=1, set_dirty[v]=0; next state FILL.
- FILL:
  - pmem_read=1 and mem_enable_sel=1 until pmem_resp.
  - In the pmem_resp cycle: wren[v]=1; write_enable_v = all ones; load_tag[v]=1; load_valid[v]=1; set_valid[v]=1; load_dirty[v]=1; set_dirty[v]=0.
  - Next state SETTLE.
- SETTLE: one idle cycle so the synchronous arrays present the new line; next state LOOKUP, which then hits.
- pmem_resp arriving in IDLE, LOOKUP or SETTLE is ignored.
- pmem_read and pmem_write are never asserted together.
- Latency, counted in cycles from request acceptance to mem_resp:
  - hit: 1.
  - clean miss: 3 + fill wait.
  - dirty miss: 3 + writeback wait + fill wait.
- CPU address and data must stay stable until mem_resp. Dropping a request before mem_resp is illegal and the behaviour is undefined.

Optional Feature:
DCACHE_PERF_CNT_EN:
- When defined, adds outputs hit_count, miss_count and writeback_count, each 32 bits.
  - hit_count increments on every LOOKUP hit not preceded by SETTLE.
  - miss_count increments on every LOOKUP miss.
  - writeback_count increments on every WRITEBACK pmem_resp.
  - All three saturate at 32'hFFFFFFFF and clear on rst.
- When not defined, these ports and registers do not exist.

Test Plan:
- Cold read, set 3 invalid, pmem_resp after 4 cycles -> pmem_read high 4 cycles; wren=2'b01 with write_enable_0=32'hFFFFFFFF, load_tag[0], load_valid[0]; SETTLE; mem_resp one cycle; set_lru=1.
- Read hit on way 1 -> mem_resp exactly 1 cycle after acceptance; load_lru=1, set_lru=0; no pmem activity.
- Write hit on way 0 with byte enable 32'h0000000F -> write_enable_0=32'h0000000F, wren=2'b01, load_dirty[0]=1 with set_dirty[0]=1, mem_resp=1.
- Dirty miss, lru_output=1, valid_out=2'b11, dirty_out=2'b10 -> pmem_write until pmem_resp, then pmem_read, then fill of way 1 with set_dirty[1]=0, then mem_resp; pmem_read and pmem_write never overlap.
- rst asserted during FILL -> next cycle state IDLE and all outputs 0; a following read is accepted normally.
- mem_read=mem_write=1 on a hit -> treated as a write (wren asserted), single mem_resp.
